// File: rtl/led_step_ctrl.sv
// led_step_ctrl: debounces the run/speed keys and emits a one-cycle step strobe for the LED rotator.
// Latency: raw key edge to run/speed update is DEB_CYCLES+2 cycles; step is registered.
// Backpressure: none; step is a free-running strobe that the downstream shifter always accepts.
// Optional feature: define LED_STEP_LONG_PRESS_EN for long-press direction reversal on key1.
module led_step_ctrl #(
   parameter int DEB_CYCLES  = 1_000_000,
   parameter int BASE_PERIOD = 10_000_000,
   parameter int LONG_CYCLES = 50_000_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [1:0] key_n,
   output logic       step,
   output logic       dir,
   output logic       run,
   output logic [1:0] speed
);

   localparam int DW = $clog2(DEB_CYCLES);
   localparam int TW = $clog2(BASE_PERIOD);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [31:0]   BASE_U   = 32'(BASE_PERIOD);

   // Refuse to elaborate with counters too narrow to mean anything.
   if (DEB_CYCLES < 2 || BASE_PERIOD < 16 || LONG_CYCLES < 2) begin : g_bad_params
      $error("led_step_ctrl: DEB_CYCLES>=2, BASE_PERIOD>=16, LONG_CYCLES>=2 required");
   end

   // ------------------------------------------------------------------
   // Two-flop synchronizers; idle at 1 so a released key reads as released.
   // ------------------------------------------------------------------
   logic [1:0] sync_a;
   logic [1:0] sync_b;

   // Bring the asynchronous key levels into the clock domain.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync_a <= 2'b11;
         sync_b <= 2'b11;
      end else begin
         sync_a <= key_n;
         sync_b <= sync_a;
      end
   end

   // ------------------------------------------------------------------
   // Debounce: a key level is accepted only after DEB_CYCLES consecutive
   // cycles of disagreement with the current stable level.
   // ------------------------------------------------------------------
   logic [1:0]    stable;
   logic [DW-1:0] deb_cnt [2];
   logic [1:0]    deb_hit;

   // deb_hit marks the edge on which a key's stable level flips.
   always_comb begin
      deb_hit = '0;
      for (int i = 0; i < 2; i++) begin
         deb_hit[i] = (sync_b[i] != stable[i]) && (deb_cnt[i] == DEB_LAST);
      end
   end

   // Per-key disagreement counter and stable level.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         stable <= 2'b11;
         for (int i = 0; i < 2; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync_b[i] == stable[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_hit[i]) begin
               stable[i]  <= sync_b[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Press = stable level falling; key0 press toggles run.
   logic run_evt;
   logic speed_evt;
   assign run_evt = deb_hit[0] & stable[0];

`ifdef LED_STEP_LONG_PRESS_EN
   // ------------------------------------------------------------------
   // Long-press variant: key1 acts on release. Holding it for LONG_CYCLES
   // stable-low cycles flips dir once and suppresses the speed change.
   // ------------------------------------------------------------------
   localparam int LW = $clog2(LONG_CYCLES);
   localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

   logic          key1_rel;
   logic [LW-1:0] hold_cnt;
   logic          long_flag;
   logic          dir_q;

   assign key1_rel  = deb_hit[1] & ~stable[1];
   assign speed_evt = key1_rel & ~long_flag;
   assign dir       = dir_q;

   // Hold timer for key1; release wins over a coincident threshold hit.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         hold_cnt  <= '0;
         long_flag <= 1'b0;
         dir_q     <= 1'b0;
      end else if (key1_rel) begin
         hold_cnt  <= '0;
         long_flag <= 1'b0;
      end else if (!stable[1] && !long_flag) begin
         if (hold_cnt == LONG_LAST) begin
            dir_q     <= ~dir_q;
            long_flag <= 1'b1;
         end else begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end
`else
   // Plain variant: key1 press advances speed, direction is fixed left.
   assign speed_evt = deb_hit[1] & stable[1];
   assign dir       = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Run / speed status, updated on the same edge as the stable level.
   // ------------------------------------------------------------------

   // Toggle run on key0 press, advance speed (wrapping) on a key1 event.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         run   <= 1'b1;
         speed <= 2'd0;
      end else begin
         if (run_evt) begin
            run <= ~run;
         end
         if (speed_evt) begin
            speed <= speed + 2'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Step timer: counts 0..P-1 with P = BASE_PERIOD >> speed. The current
   // run value gates counting, so the pausing edge still counts once and
   // the resuming edge still holds; the held count is kept across a pause.
   // ------------------------------------------------------------------
   logic [TW-1:0] tmr;
   logic [TW-1:0] tmr_last;

   // Terminal count for the current speed.
   always_comb begin
      tmr_last = TW'((BASE_U >> speed) - 32'd1);
   end

   // Period counter and registered step strobe; a speed change restarts the period.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         tmr  <= '0;
         step <= 1'b0;
      end else if (speed_evt) begin
         tmr  <= '0;
         step <= 1'b0;
      end else if (run) begin
         if (tmr == tmr_last) begin
            tmr  <= '0;
            step <= 1'b1;
         end else begin
            tmr  <= tmr + 1'b1;
            step <= 1'b0;
         end
      end else begin
         step <= 1'b0;
      end
   end

endmodule

// File: tb/tb_led_step_ctrl.sv
// Bench for led_step_ctrl with DEB_CYCLES=4, BASE_PERIOD=64, LONG_CYCLES=32.
// Expected step cycles go into a queue as stimulus is applied and are popped when a pulse shows up.
// Outputs are sampled 1 ns after the rising edge; cyc counts rising edges.
module tb_led_step_ctrl;

   localparam int DEB  = 4;
   localparam int BASE = 64;
   localparam int LONG = 32;

   logic       sys_clk;
   logic       sys_rst;
   logic [1:0] key_n;
   logic       step;
   logic       dir;
   logic       run;
   logic [1:0] speed;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int exp_speed = 0;
   int exp_q[$];

   led_step_ctrl #(
      .DEB_CYCLES (DEB),
      .BASE_PERIOD(BASE),
      .LONG_CYCLES(LONG)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .key_n  (key_n),
      .step   (step),
      .dir    (dir),
      .run    (run),
      .speed  (speed)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   // Advance until step is seen high or the budget runs out (at = -1).
   task automatic wait_step(input int budget, output int at);
      int n;
      n  = 0;
      at = -1;
      while (at < 0 && n < budget) begin
         tick(1);
         n++;
         if (step === 1'b1) at = cyc;
      end
   endtask

   task automatic press(input int idx, input int len);
      key_n[idx] = 1'b0;
      tick(len);
      key_n[idx] = 1'b1;
      tick(20);
   endtask

   task automatic test_reset();
      int base, at, ex;
      sys_rst = 1'b1;
      key_n   = 2'b11;
      tick(3);
      tests++; if (step !== 1'b0) begin fails++; $display("FAIL reset_step: got %0b want 0", step); end
      tests++; if (dir !== 1'b0) begin fails++; $display("FAIL reset_dir: got %0b want 0", dir); end
      tests++; if (run !== 1'b1) begin fails++; $display("FAIL reset_run: got %0b want 1", run); end
      tests++; if (speed !== 2'd0) begin fails++; $display("FAIL reset_speed: got %0d want 0", speed); end
      sys_rst = 1'b0;
      base = cyc;
      for (int k = 1; k <= 3; k++) exp_q.push_back(base + BASE * k);
      for (int k = 1; k <= 3; k++) begin
         wait_step(80, at);
         ex = exp_q.pop_front();
         tests++; if (at !== ex) begin fails++; $display("FAIL idle_step%0d: at cycle %0d want %0d", k, at, ex); end
         tick(1);
         tests++; if (step !== 1'b0) begin fails++; $display("FAIL step_width%0d: got %0b want 0", k, step); end
      end
      tests++; if (run !== 1'b1 || speed !== 2'd0 || dir !== 1'b0) begin
         fails++; $display("FAIL idle_status: run=%0b speed=%0d dir=%0b want 1/0/0", run, speed, dir);
      end
   endtask

   task automatic test_glitch();
      key_n[0] = 1'b0;
      tick(3);
      key_n[0] = 1'b1;
      tick(12);
      tests++; if (run !== 1'b1) begin fails++; $display("FAIL glitch_run: got %0b want 1", run); end
   endtask

   task automatic test_pause();
      int s, at, ex, r, cnt;
      wait_step(80, s);
      tick(10);                        // count is 10 at the key fall
      key_n[0] = 1'b0;
      tick(5);
      tests++; if (run !== 1'b1) begin fails++; $display("FAIL pause_early: run=%0b want 1", run); end
      tick(1);                         // toggle edge: the timer counts once more, held count 16
      tests++; if (run !== 1'b0) begin fails++; $display("FAIL pause_run: run=%0b want 0", run); end
      tick(4);
      key_n[0] = 1'b1;
      cnt = 0;
      for (int i = 0; i < 80; i++) begin
         tick(1);
         if (step === 1'b1) cnt++;
      end
      tests++; if (cnt !== 0) begin fails++; $display("FAIL pause_nostep: %0d pulses want 0", cnt); end
      key_n[0] = 1'b0;
      tick(6);
      r = cyc;
      tests++; if (run !== 1'b1) begin fails++; $display("FAIL resume_run: run=%0b want 1", run); end
      key_n[0] = 1'b1;
      exp_q.push_back(r + BASE - 16);
      wait_step(80, at);
      ex = exp_q.pop_front();
      tests++; if (at !== ex) begin fails++; $display("FAIL resume_step: at cycle %0d want %0d", at, ex); end
   endtask

   task automatic test_speed();
      int c, at, ex;
      key_n[1] = 1'b0;
`ifdef LED_STEP_LONG_PRESS_EN
      tick(10);
      key_n[1] = 1'b1;
`endif
      tick(5);
      tests++; if (speed !== 2'd0) begin fails++; $display("FAIL speed_early: got %0d want 0", speed); end
      tick(1);
      exp_speed = 1;
      tests++; if (speed !== 2'd1) begin fails++; $display("FAIL speed_up: got %0d want 1", speed); end
      c = cyc;
      exp_q.push_back(c + BASE / 2);
      exp_q.push_back(c + BASE);
      tick(4);
      key_n[1] = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         wait_step(40, at);
         ex = exp_q.pop_front();
         tests++; if (at !== ex) begin fails++; $display("FAIL speed1_step%0d: at cycle %0d want %0d", k, at, ex); end
      end
      for (int k = 0; k < 3; k++) begin
         press(1, 10);
         exp_speed = (exp_speed + 1) % 4;
         tests++; if (speed !== 2'(exp_speed)) begin fails++; $display("FAIL speed_press%0d: got %0d want %0d", k, speed, exp_speed); end
      end
      tests++; if (speed !== 2'd0) begin fails++; $display("FAIL speed_wrap: got %0d want 0", speed); end
   endtask

   task automatic test_simultaneous();
      int r, at, ex, s0;
      s0 = exp_speed;
`ifdef LED_STEP_LONG_PRESS_EN
      key_n = 2'b01;                   // short key1 hold so its release lines up with key0 press
      tick(12);
      key_n = 2'b10;
`else
      key_n = 2'b00;
`endif
      tick(5);
      tests++; if (run !== 1'b1 || speed !== 2'(s0)) begin
         fails++; $display("FAIL simul_early: run=%0b speed=%0d want 1/%0d", run, speed, s0);
      end
      tick(1);
      exp_speed = (s0 + 1) % 4;
      tests++; if (run !== 1'b0 || speed !== 2'(exp_speed)) begin
         fails++; $display("FAIL simul_edge: run=%0b speed=%0d want 0/%0d", run, speed, exp_speed);
      end
      key_n = 2'b11;
      tick(20);
      key_n[0] = 1'b0;
      tick(6);
      r = cyc;
      key_n[0] = 1'b1;
      exp_q.push_back(r + (BASE >> exp_speed));
      wait_step(80, at);
      ex = exp_q.pop_front();
      tests++; if (at !== ex) begin fails++; $display("FAIL simul_timer_clear: at cycle %0d want %0d", at, ex); end
   endtask

   task automatic test_long_press();
      int s0;
      s0 = exp_speed;
`ifdef LED_STEP_LONG_PRESS_EN
      key_n[1] = 1'b0;
      tick(37);
      tests++; if (dir !== 1'b0) begin fails++; $display("FAIL long_dir_early: got %0b want 0", dir); end
      tick(1);
      tests++; if (dir !== 1'b1) begin fails++; $display("FAIL long_dir: got %0b want 1", dir); end
      tick(12);
      key_n[1] = 1'b1;
      tick(20);
      tests++; if (speed !== 2'(s0) || dir !== 1'b1) begin
         fails++; $display("FAIL long_release: speed=%0d dir=%0b want %0d/1", speed, dir, s0);
      end
      key_n[1] = 1'b0;
      tick(10);
      key_n[1] = 1'b1;
      tick(5);
      tests++; if (speed !== 2'(s0)) begin fails++; $display("FAIL short_early: got %0d want %0d", speed, s0); end
      tick(1);
      exp_speed = (s0 + 1) % 4;
      tests++; if (speed !== 2'(exp_speed)) begin fails++; $display("FAIL short_speed: got %0d want %0d", speed, exp_speed); end
      tick(10);
`else
      key_n[1] = 1'b0;
      tick(50);
      exp_speed = (s0 + 1) % 4;
      tests++; if (dir !== 1'b0 || speed !== 2'(exp_speed)) begin
         fails++; $display("FAIL hold_nodir: dir=%0b speed=%0d want 0/%0d", dir, speed, exp_speed);
      end
      key_n[1] = 1'b1;
      tick(20);
      tests++; if (dir !== 1'b0 || speed !== 2'(exp_speed)) begin
         fails++; $display("FAIL hold_release: dir=%0b speed=%0d want 0/%0d", dir, speed, exp_speed);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int s, at, ex, base;
      while (exp_speed != 2) begin
         press(1, 10);
         exp_speed = (exp_speed + 1) % 4;
      end
      tests++; if (speed !== 2'd2 || run !== 1'b1) begin
         fails++; $display("FAIL mid_setup: speed=%0d run=%0b want 2/1", speed, run);
      end
      wait_step(40, s);
      tick(10);
      key_n[0] = 1'b0;                 // pause lands on the next pulse edge (16 cycles after s)
      tick(6);
      tests++; if (step !== 1'b1 || run !== 1'b0) begin
         fails++; $display("FAIL mid_pre: step=%0b run=%0b want 1/0", step, run);
      end
      #2;
      sys_rst = 1'b1;
      #1;
      tests++; if (step !== 1'b0 || dir !== 1'b0 || run !== 1'b1 || speed !== 2'd0) begin
         fails++; $display("FAIL mid_async: step=%0b dir=%0b run=%0b speed=%0d want 0/0/1/0", step, dir, run, speed);
      end
      key_n = 2'b11;
      exp_speed = 0;
      tick(2);
      sys_rst = 1'b0;
      base = cyc;
      exp_q.push_back(base + BASE);
      wait_step(80, at);
      ex = exp_q.pop_front();
      tests++; if (at !== ex) begin fails++; $display("FAIL mid_restart_step: at cycle %0d want %0d", at, ex); end
   endtask

   initial begin
      sys_rst = 1'b1;
      key_n   = 2'b11;
      test_reset();
      test_glitch();
      test_pause();
      test_speed();
      test_simultaneous();
      test_long_press();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
